spi_rx_fifo: RTL and testbench

Parametrised successor to the fixed 8-bit SPI read front-end. Receives SPI slave data in any of the four CPOL/CPHA modes, with configurable word width and bit order, and honours chip select. Buffers received words in a show-ahead FIFO in the clk_24m domain. Sits between the external SPI host pins and the DJS130 peripheral logic that drains it.

---
 rtl/djs130_spi_pkg.sv | 17 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/spi_rx_fifo.sv | 159 +++++++++++++++
 tb/tb_spi_rx_fifo.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/djs130_spi_pkg.sv
// Shared types and helpers for the DJS130 SPI receive front-end.
package djs130_spi_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } spi_rx_state_e;

  // Data is sampled on the rising spi_clk edge when CPOL equals CPHA, else on the falling edge.
  function automatic logic sample_on_rise(input int cpol, input int cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty/level status; DEPTH must be a power of two.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     count_q;
  logic              do_rd;
  logic              do_wr;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LW'(DEPTH));
  assign level_o = count_q;

  // A write into a full FIFO is legal when the head leaves in the same cycle.
  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; stale entries are never visible because count_q gates them.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_rx_fifo.sv
// SPI slave receiver (any CPOL/CPHA, configurable width/bit order) feeding a show-ahead FIFO.
// Define SPI_RX_CS_BYPASS_EN to ignore spi_cs_n for hosts without a chip-select line.
module spi_rx_fifo
  import djs130_spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          clk_24m,
  input  logic                          rst,
  input  logic                          spi_cs_n,
  input  logic                          spi_clk,
  input  logic                          spi_mosi,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          ovf_clr,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int   CNT_W     = $clog2(DATA_W);
  localparam logic SCLK_IDLE = 1'(CPOL);
  localparam logic RISE      = sample_on_rise(CPOL, CPHA);

  logic [SYNC_STAGES:0]   sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_s;
  logic                   sclk_prev;
  logic                   mosi_s;
  logic                   sample;
  logic                   cs_active;

  spi_rx_state_e          state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [DATA_W-1:0]      shreg_q;
  logic [DATA_W-1:0]      shreg_d;
  logic                   frame_err_q;
  logic                   overflow_q;

  logic                   push_en;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   drop;

  // Synchronisers reset to the idle pin levels so reset release never looks like an edge.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= {(SYNC_STAGES + 1){SCLK_IDLE}};
      mosi_sync_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage captures the previous stage's old value.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

`ifdef SPI_RX_CS_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{spi_cs_n, frame_err_q};
  assign cs_active     = 1'b1;
  assign frame_err     = 1'b0;
`else
  logic [SYNC_STAGES-1:0] cs_sync_q;

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) cs_sync_q <= '1;
    else     cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
  end

  assign cs_active = ~cs_sync_q[SYNC_STAGES-1];
  assign frame_err = frame_err_q;
`endif

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sclk_prev = sclk_sync_q[SYNC_STAGES];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sample    = RISE ? (sclk_s & ~sclk_prev) : (~sclk_s & sclk_prev);

  always_comb begin
    // NOTE: both branches assign shreg_d, so no latch can be inferred.
    if (MSB_FIRST != 0) shreg_d = {shreg_q[DATA_W-2:0], mosi_s};
    else                shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_active) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
          end
        end
        SHIFT: begin
          // Chip-select release wins over a coincident sample: the word is incomplete.
          if (!cs_active) begin
            state_q     <= IDLE;
            frame_err_q <= (bit_cnt_q != '0);
          end else if (sample) begin
            shreg_q <= shreg_d;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= PUSH;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        PUSH: begin
          state_q <= cs_active ? SHIFT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push_en = (state_q == PUSH);
  assign pop     = rd_en & ~fifo_empty;
  assign drop    = push_en & fifo_full & ~pop;

  // Set has priority over clear so a drop is never lost to a coincident ovf_clr.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst)          overflow_q <= 1'b0;
    else if (drop)    overflow_q <= 1'b1;
    else if (ovf_clr) overflow_q <= 1'b0;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_24m),
    .rst       (rst),
    .wr_en_i   (push_en),
    .wr_data_i (shreg_q),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign rd_valid = ~fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed scoreboard bench for spi_rx_fifo: four instances cover the four SPI modes (mode 3 is LSB-first).
module tb_spi_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NI    = 4;

  logic          clk_24m  = 1'b0;
  logic          rst      = 1'b1;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic [NI-1:0] sclk     = 4'b1100;
  logic [NI-1:0] rd_en    = '0;
  logic [NI-1:0] ovf_clr  = '0;

  logic [DW-1:0] rd_data    [NI];
  logic          rd_valid   [NI];
  logic [2:0]    fifo_level [NI];
  logic          overflow   [NI];
  logic          frame_err  [NI];

  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt   = 0;

  always #5 clk_24m = ~clk_24m;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_rx_fifo #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .CPOL       ((g >> 1) & 1),
      .CPHA       (g & 1),
      .MSB_FIRST  ((g == 3) ? 0 : 1)
    ) u_dut (
      .clk_24m    (clk_24m),
      .rst        (rst),
      .spi_cs_n   (spi_cs_n),
      .spi_clk    (sclk[g]),
      .spi_mosi   (spi_mosi),
      .rd_en      (rd_en[g]),
      .rd_data    (rd_data[g]),
      .rd_valid   (rd_valid[g]),
      .fifo_level (fifo_level[g]),
      .ovf_clr    (ovf_clr[g]),
      .overflow   (overflow[g]),
      .frame_err  (frame_err[g])
    );
  end

  // Counts every cycle the mode-0 instance reports a frame error.
  always @(negedge clk_24m) if (frame_err[0]) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [7:0] exp_for(input int m, input logic [7:0] w);
    return (m == 3) ? bitrev8(w) : w;
  endfunction

  // Host always shifts MSB first on the wire; half period of 4 clk_24m cycles.
  task automatic send_bits(input int m, input logic [7:0] w, input int nb, input bit pop_sync);
    logic [7:0] v;
    v = w;
    @(negedge clk_24m);
    for (int i = 0; i < nb; i++) begin
      if ((m & 1) == 0) begin
        spi_mosi = v[7-i];
        #40;
        sclk[m] = ~sclk[m];
        if (pop_sync && i == nb - 1) begin
          logic [7:0] e;
          // Sample lands 3 cycles after this edge, the write 1 cycle later: pop in that cycle.
          #30;
          e = exp_q.pop_front();
          check("full_pop_head", rd_data[0], e);
          rd_en[0] = 1'b1;
          #10;
          rd_en[0] = 1'b0;
        end else begin
          #40;
        end
        sclk[m] = ~sclk[m];
      end else begin
        sclk[m] = ~sclk[m];
        spi_mosi = v[7-i];
        #40;
        sclk[m] = ~sclk[m];
        #40;
      end
    end
  endtask

  task automatic cs_low();
    @(negedge clk_24m);
    spi_cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40;
    spi_cs_n = 1'b1;
    #100;
  endtask

  task automatic pop_check(input int idx, input string tag);
    int t;
    logic [7:0] e;
    t = 0;
    @(negedge clk_24m);
    while (!rd_valid[idx] && t < 300) begin
      @(negedge clk_24m);
      t++;
    end
    e = exp_q.pop_front();
    if (!rd_valid[idx]) begin
      check({tag, "_valid"}, 32'(rd_valid[idx]), 32'd1);
    end else begin
      check(tag, rd_data[idx], e);
      rd_en[idx] = 1'b1;
      @(negedge clk_24m);
      rd_en[idx] = 1'b0;
    end
  endtask

  task automatic reset_mid_word();
    send_bits(0, 8'h77, 8, 1'b0);
    send_bits(0, 8'hC3, 4, 1'b0);
    #13;
    rst = 1'b1;
    #1;
    check("rst_rd_valid", 32'(rd_valid[0]), 32'd0);
    check("rst_level", 32'(fifo_level[0]), 32'd0);
    check("rst_overflow", 32'(overflow[0]), 32'd0);
    check("rst_frame_err", 32'(frame_err[0]), 32'd0);
  endtask

  initial begin
    int fe_base;
    logic [7:0] w;

    #22;
    check("init_rd_valid", 32'(rd_valid[0]), 32'd0);
    check("init_level", 32'(fifo_level[0]), 32'd0);
    check("init_overflow", 32'(overflow[0]), 32'd0);
    check("init_frame_err", 32'(frame_err[0]), 32'd0);
    @(negedge clk_24m);
    rst = 1'b0;
    repeat (4) @(negedge clk_24m);

`ifndef SPI_RX_CS_BYPASS_EN
    // Two words in one frame, mode 0.
    cs_low();
    send_bits(0, 8'hA5, 8, 1'b0);
    send_bits(0, 8'h3C, 8, 1'b0);
    cs_high();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    check("t1_rd_valid", 32'(rd_valid[0]), 32'd1);
    check("t1_level", 32'(fifo_level[0]), 32'd2);
    pop_check(0, "t1_word0");
    pop_check(0, "t1_word1");

    // Remaining modes; mode 3 instance is LSB-first.
    for (int m = 1; m < NI; m++) begin
      cs_low();
      send_bits(m, 8'h01, 8, 1'b0);
      cs_high();
      exp_q.push_back(exp_for(m, 8'h01));
      pop_check(m, "t2_mode_word");
    end
    cs_low();
    send_bits(3, 8'h35, 8, 1'b0);
    cs_high();
    exp_q.push_back(exp_for(3, 8'h35));
    pop_check(3, "t2_lsb_first");

    // Partial word then a good word.
    fe_base = fe_cnt;
    cs_low();
    send_bits(0, 8'hFF, 5, 1'b0);
    cs_high();
    check("t3_fe_pulses", 32'(fe_cnt - fe_base), 32'd1);
    check("t3_fe_low", 32'(frame_err[0]), 32'd0);
    check("t3_level", 32'(fifo_level[0]), 32'd0);
    check("t3_rd_valid", 32'(rd_valid[0]), 32'd0);
    cs_low();
    send_bits(0, 8'h5A, 8, 1'b0);
    cs_high();
    exp_q.push_back(8'h5A);
    pop_check(0, "t3_after_err");

    // Five words into a four-entry FIFO.
    cs_low();
    for (int k = 0; k < 5; k++) begin
      w = 8'h10 + 8'(k);
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      send_bits(0, w, 8, 1'b0);
    end
    cs_high();
    check("t4_overflow", 32'(overflow[0]), 32'd1);
    check("t4_level", 32'(fifo_level[0]), 32'd4);
    for (int k = 0; k < DEPTH; k++) pop_check(0, "t4_pop");
    check("t4_drained", 32'(rd_valid[0]), 32'd0);
    @(negedge clk_24m);
    ovf_clr[0] = 1'b1;
    @(negedge clk_24m);
    ovf_clr[0] = 1'b0;
    check("t4_ovf_clr", 32'(overflow[0]), 32'd0);

    // Pop request on an empty FIFO.
    @(negedge clk_24m);
    rd_en[0] = 1'b1;
    @(negedge clk_24m);
    rd_en[0] = 1'b0;
    @(negedge clk_24m);
    check("t5_empty_rd_level", 32'(fifo_level[0]), 32'd0);
    check("t5_empty_rd_valid", 32'(rd_valid[0]), 32'd0);

    // Push into a full FIFO with a same-cycle pop.
    cs_low();
    for (int k = 0; k < DEPTH; k++) begin
      w = 8'h20 + 8'(k);
      exp_q.push_back(w);
      send_bits(0, w, 8, 1'b0);
    end
    send_bits(0, 8'h24, 8, 1'b1);
    exp_q.push_back(8'h24);
    cs_high();
    check("t5_no_overflow", 32'(overflow[0]), 32'd0);
    check("t5_level_full", 32'(fifo_level[0]), 32'd4);
    for (int k = 0; k < DEPTH; k++) pop_check(0, "t5_order");

    // Reset after four bits of a word, with an unread word queued.
    cs_low();
    reset_mid_word();
    fe_base = fe_cnt;
    spi_cs_n = 1'b1;
    #25;
    rst = 1'b0;
    repeat (10) @(negedge clk_24m);
    check("t6_no_frame_err", 32'(fe_cnt - fe_base), 32'd0);
    cs_low();
    send_bits(0, 8'hC3, 8, 1'b0);
    cs_high();
    exp_q.push_back(8'hC3);
    pop_check(0, "t6_after_rst");
    check("t6_level_end", 32'(fifo_level[0]), 32'd0);
`else
    // No chip select: word alignment from reset only, spi_cs_n stays high.
    repeat (4) @(negedge clk_24m);
    send_bits(0, 8'hC3, 8, 1'b0);
    #100;
    exp_q.push_back(8'hC3);
    pop_check(0, "byp_word0");
    send_bits(0, 8'h5A, 8, 1'b0);
    #100;
    exp_q.push_back(8'h5A);
    pop_check(0, "byp_word1");
    check("byp_level", 32'(fifo_level[0]), 32'd0);
    reset_mid_word();
    #25;
    rst = 1'b0;
    repeat (10) @(negedge clk_24m);
    send_bits(0, 8'hC3, 8, 1'b0);
    #100;
    exp_q.push_back(8'hC3);
    pop_check(0, "byp_after_rst");
    check("byp_no_frame_err", 32'(fe_cnt), 32'd0);
    check("byp_level_end", 32'(fifo_level[0]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
